// File: rtl/status_reg.sv
// Processor status register (N,V,-,B,D,I,Z,C) with deferred ALU flag capture and SO-pin edge capture.
// Define STATUS_CMOS_EN so that interrupt entry also clears D (65C02 behaviour).
module status_reg (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       RDY,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       ld_p,
  input  logic [7:0] db_in,
  input  logic       flag_wr,
  input  logic [1:0] flag_sel,
  input  logic       flag_val,
  input  logic       irq_entry,
  input  logic       so_n,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       c_out,
  output logic       d_out
);

  typedef enum logic [1:0] {
    SEL_C = 2'd0,
    SEL_I = 2'd1,
    SEL_D = 2'd2,
    SEL_V = 2'd3
  } flag_sel_e;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic pend_nz_q, pend_c_q, pend_v_q;
  logic pend_nz_d, pend_c_d, pend_v_d;
  logic so_pend_q, so_pend_d;
  logic so_s1_q, so_s2_q, so_s3_q;
  logic so_edge;

  // PHP/BRK bits 5 and 4 come from the pushed value, not from db_in.
  logic unused_db_bits;
  assign unused_db_bits = ^db_in[5:4];

  // Synchronized high-to-low transition of the SO pin; flops idle high so reset release is quiet.
  assign so_edge = so_s3_q & ~so_s2_q;

  // Priority is expressed by assignment order: later assignments win.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    n_d       = n_q;
    v_d       = v_q;
    d_d       = d_q;
    i_d       = i_q;
    z_d       = z_q;
    c_d       = c_q;
    pend_nz_d = pend_nz_q;
    pend_c_d  = pend_c_q;
    pend_v_d  = pend_v_q;
    if (RDY) begin
      pend_nz_d = upd_nz & ~ld_p;
      pend_c_d  = upd_c  & ~ld_p;
      pend_v_d  = upd_v  & ~ld_p;
      if (flag_wr) begin
        unique case (flag_sel_e'(flag_sel))
          SEL_C: c_d = flag_val;
          SEL_I: i_d = flag_val;
          SEL_D: d_d = flag_val;
          SEL_V: v_d = flag_val;
        endcase
      end
      if (irq_entry) begin
        i_d = 1'b1;
`ifdef STATUS_CMOS_EN
        d_d = 1'b0;
`else
        d_d = d_d;
`endif
      end
      if (pend_nz_q) begin
        n_d = alu_n;
        z_d = alu_z;
      end
      if (pend_c_q) c_d = alu_co;
      if (pend_v_q) v_d = alu_v;
      if (so_pend_q) v_d = 1'b1;
      if (ld_p) begin
        n_d = db_in[7];
        v_d = db_in[6];
        d_d = db_in[3];
        i_d = db_in[2];
        z_d = db_in[1];
        c_d = db_in[0];
      end
    end
  end

  // A new SO edge wins over consumption; ld_p defers consumption to the next RDY edge.
  always_comb begin
    so_pend_d = so_edge | (so_pend_q & ~(RDY & ~ld_p));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      d_q       <= 1'b0;
      i_q       <= 1'b1;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      pend_nz_q <= 1'b0;
      pend_c_q  <= 1'b0;
      pend_v_q  <= 1'b0;
      so_pend_q <= 1'b0;
      so_s1_q   <= 1'b1;
      so_s2_q   <= 1'b1;
      so_s3_q   <= 1'b1;
    end else begin
      n_q       <= n_d;
      v_q       <= v_d;
      d_q       <= d_d;
      i_q       <= i_d;
      z_q       <= z_d;
      c_q       <= c_d;
      pend_nz_q <= pend_nz_d;
      pend_c_q  <= pend_c_d;
      pend_v_q  <= pend_v_d;
      so_pend_q <= so_pend_d;
      so_s1_q   <= so_n;
      so_s2_q   <= so_s1_q;
      so_s3_q   <= so_s2_q;
    end
  end

  assign p_out  = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign p_push = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign c_out  = c_q;
  assign d_out  = d_q;

endmodule
